// File: rtl/fx_arb.sv
// ---------------------------------------------------------------------------
// fx_arb : two-master arbiter for the fx register bus.
//
// Serialises single-byte read/write requests from master 0 (UART command
// master) and master 1 (SPI/MCU host) onto the single fx master port, and
// returns read data plus a one-cycle completion acknowledge to the owner.
//
// Build option:
//   FX_ARB_RR_EN  defined   -> round-robin arbitration (pointer toggles after
//                              every completed transaction, reset favours m0)
//                 undefined -> fixed priority, m0 always wins ties
//
// Parameter:
//   RD_LAT   cycles from the fx_rd pulse to the cycle in which fx_q is valid
//            (legal range 1..7)
//
// Ports:
//   clk_sys, rst_n                     clock, async active-low reset
//   mX_req/mX_we/mX_addr/mX_wdata      master X request (X = 0, 1)
//   mX_ack/mX_rdata                    master X completion / read data
//   fx_wr/fx_waddr/fx_data             fx bus write strobe, address, data
//   fx_rd/fx_raddr/fx_q                fx bus read strobe, address, data
//   busy                               high whenever the FSM is not IDLE
//
// All outputs are registers; they are computed from the next state so that
// strobes appear in the cycle the FSM occupies the matching state.
// ---------------------------------------------------------------------------
module fx_arb #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic        fx_wr,
  output logic [21:0] fx_waddr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [21:0] fx_raddr,
  input  logic [7:0]  fx_q,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state_r, state_nxt;
  logic        owner_r, owner_nxt;
  logic        we_r, we_nxt;
  logic [21:0] addr_r, addr_nxt;
  logic [7:0]  wdata_r, wdata_nxt;
  logic [2:0]  cnt_r, cnt_nxt;
  logic        capture_s;
  logic        win_s;

  logic        fx_wr_r, fx_wr_nxt;
  logic [21:0] fx_waddr_r, fx_waddr_nxt;
  logic [7:0]  fx_data_r, fx_data_nxt;
  logic        fx_rd_r, fx_rd_nxt;
  logic [21:0] fx_raddr_r, fx_raddr_nxt;
  logic        m0_ack_r, m0_ack_nxt;
  logic        m1_ack_r, m1_ack_nxt;
  logic        busy_r, busy_nxt;
  logic [7:0]  m0_rdata_r;
  logic [7:0]  m1_rdata_r;

`ifdef FX_ARB_RR_EN
  // 0 favours m0, 1 favours m1
  logic        ptr_r;

  // Round-robin pointer: flips after every completed transaction
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (state_r == DONE) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Winner select: a lone requester wins, a tie goes to the favoured master
  always_comb begin
    win_s = m1_req && (!m0_req || ptr_r);
  end
`else
  // Winner select: m1 wins only when m0 is not requesting
  always_comb begin
    win_s = m1_req && !m0_req;
  end
`endif

  // Next-state, transaction latch and read-capture decode
  always_comb begin
    state_nxt = state_r;
    owner_nxt = owner_r;
    we_nxt    = we_r;
    addr_nxt  = addr_r;
    wdata_nxt = wdata_r;
    cnt_nxt   = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_nxt = win_s;
          we_nxt    = win_s ? m1_we    : m0_we;
          addr_nxt  = win_s ? m1_addr  : m0_addr;
          wdata_nxt = win_s ? m1_wdata : m0_wdata;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = LAT_M1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // fx_q is valid in the cycle where the countdown reaches zero
        if (cnt_r == 3'd0) begin
          capture_s = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_r - 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the state about to be entered, so strobes are registered
  always_comb begin
    fx_wr_nxt    = 1'b0;
    fx_waddr_nxt = 22'd0;
    fx_data_nxt  = 8'd0;
    fx_rd_nxt    = 1'b0;
    fx_raddr_nxt = 22'd0;
    m0_ack_nxt   = 1'b0;
    m1_ack_nxt   = 1'b0;
    busy_nxt     = (state_nxt != IDLE);
    if ((state_nxt == ISSUE) && we_nxt) begin
      fx_wr_nxt    = 1'b1;
      fx_waddr_nxt = addr_nxt;
      fx_data_nxt  = wdata_nxt;
    end else begin
      fx_wr_nxt    = 1'b0;
    end
    // read address is held from the strobe through the capture cycle
    if (!we_nxt && ((state_nxt == ISSUE) || (state_nxt == WAIT))) begin
      fx_raddr_nxt = addr_nxt;
      fx_rd_nxt    = (state_nxt == ISSUE);
    end else begin
      fx_raddr_nxt = 22'd0;
    end
    if (state_nxt == DONE) begin
      m0_ack_nxt = !owner_nxt;
      m1_ack_nxt = owner_nxt;
    end else begin
      m0_ack_nxt = 1'b0;
      m1_ack_nxt = 1'b0;
    end
  end

  // State, transaction latch and registered outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 22'd0;
      wdata_r    <= 8'd0;
      cnt_r      <= 3'd0;
      fx_wr_r    <= 1'b0;
      fx_waddr_r <= 22'd0;
      fx_data_r  <= 8'd0;
      fx_rd_r    <= 1'b0;
      fx_raddr_r <= 22'd0;
      m0_ack_r   <= 1'b0;
      m1_ack_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      owner_r    <= owner_nxt;
      we_r       <= we_nxt;
      addr_r     <= addr_nxt;
      wdata_r    <= wdata_nxt;
      cnt_r      <= cnt_nxt;
      fx_wr_r    <= fx_wr_nxt;
      fx_waddr_r <= fx_waddr_nxt;
      fx_data_r  <= fx_data_nxt;
      fx_rd_r    <= fx_rd_nxt;
      fx_raddr_r <= fx_raddr_nxt;
      m0_ack_r   <= m0_ack_nxt;
      m1_ack_r   <= m1_ack_nxt;
      busy_r     <= busy_nxt;
    end
  end

  // Read data capture into the owner's register; the other is left untouched
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata_r <= 8'd0;
      m1_rdata_r <= 8'd0;
    end else if (capture_s) begin
      if (owner_r) begin
        m1_rdata_r <= fx_q;
      end else begin
        m0_rdata_r <= fx_q;
      end
    end else begin
      m0_rdata_r <= m0_rdata_r;
      m1_rdata_r <= m1_rdata_r;
    end
  end

  assign fx_wr    = fx_wr_r;
  assign fx_waddr = fx_waddr_r;
  assign fx_data  = fx_data_r;
  assign fx_rd    = fx_rd_r;
  assign fx_raddr = fx_raddr_r;
  assign m0_ack   = m0_ack_r;
  assign m1_ack   = m1_ack_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_rdata = m1_rdata_r;
  assign busy     = busy_r;

endmodule

// File: doc/fx_arb.md
# fx_arb

Two-master arbiter for the fx register bus. It sits between the UART command master and a second host master (SPI/MCU), ahead of the fx bus fan-out. It serialises their single-byte read/write requests onto the one shared fx master port and returns read data and a completion acknowledge to the owning master. Each transaction is sequenced through a small FSM with a parameterised read-return latency.

## Interface
- `RD_LAT`, default 2: number of cycles from the fx_rd pulse to the cycle in which fx_q is valid. Legal range is 1..7.
- `clk_sys`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `m0_req`  in  1  master 0 (UART) request; held high until m0_ack
- `m0_we`  in  1  1 = write, 0 = read; stable while m0_req is high
- `m0_addr`  in  22  byte address
- `m0_wdata`  in  8  write data
- `m0_ack`  out  1  one-cycle completion pulse
- `m0_rdata`  out  8  read data; valid in the m0_ack cycle and held until the next m0 read completes
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical set for master 1
- `fx_wr`  out  1  write strobe to the fx bus
- `fx_waddr`  out  22  write address
- `fx_data`  out  8  write data
- `fx_rd`  out  1  read strobe to the fx bus
- `fx_raddr`  out  22  read address
- `fx_q`  in  8  OR-combined slave read data
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. The encoding is free.
- IDLE
  - Samples m0_req and m1_req.
  - If either is high, it picks the winner and latches that master's we, addr and wdata plus a 1-bit owner register, then goes to ISSUE.
  - If neither is high, it stays in IDLE.
- ISSUE (exactly one cycle)
  - For a write: fx_wr=1 and fx_waddr/fx_data take the latched values. Next state is DONE.
  - For a read: fx_rd=1 and fx_raddr takes the latched address. A counter loads RD_LAT-1. Next state is WAIT.
- WAIT
  - The counter decrements each cycle.
  - When the counter is 0, fx_q is captured into the owner's rdata register and the next state is DONE.
  - With RD_LAT=1, WAIT lasts one cycle, and the capture is in that cycle.
- DONE
  - The owner's ack is driven high for one cycle. Next state is IDLE.
- Address/data hold on the bus:
  - fx_raddr holds the latched address from ISSUE through the capture cycle. It is 0 otherwise.
  - fx_waddr and fx_data are non-zero only in the ISSUE cycle of a write. They are 0 otherwise.
- Request rules for masters:
  - A master deasserts req at the first clock edge after its ack.
  - IDLE never re-grants a request whose ack was issued in the preceding DONE cycle.
- Early request drop:
  - If req falls before ack, the transaction still completes and ack still pulses.
  - req is only sampled in IDLE.
- The non-owner's ack is always 0. The non-owner's rdata is untouched.

## Timing
- Reset values: fx_wr=0, fx_rd=0, fx_waddr=0, fx_raddr=0, fx_data=0, m0_ack=0, m1_ack=0, m0_rdata=0, m1_rdata=0, busy=0. State is IDLE and the round-robin pointer favours m0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued, and the strobes drop asynchronously.
- Write: req is seen in IDLE at cycle T. fx_wr is high in T+1. ack is high in T+2. Total 3 cycles from req to ack.
- Read: req is seen at T. fx_rd is high in T+1. fx_q is captured at the end of cycle T+1+RD_LAT. ack is high in T+2+RD_LAT.
- Back-to-back transactions: the next grant happens in the IDLE cycle after DONE. Minimum bus occupancy per write is 3 cycles.
- Strobes are single-cycle and registered. There is no combinational path from req to fx_* or from fx_q to rdata.

## Configuration
- `FX_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - The pointer toggles to favour the other master after every DONE.
  - When both requests are high in IDLE, the favoured master wins.
- `FX_ARB_RR_EN` undefined:
  - Fixed priority; m0 (UART) always wins simultaneous requests.
  - There is no pointer register.
  - m1 can be starved while m0 keeps requesting.

## Test plan
- Write, m0, addr 0x000123, wdata 0xA5 → fx_wr is high for exactly 1 cycle with fx_waddr=0x000123 and fx_data=0xA5. m0_ack is high 1 cycle later. m1_ack stays 0.
- Read, m1, addr 0x200010, RD_LAT=2, with the bench model driving fx_q=0x3C two cycles after fx_rd → m1_rdata=0x3C at m1_ack. m1_ack is 4 cycles after req is sampled. fx_raddr is 0 after the capture cycle.
- m0 and m1 both request continuously with writes, FX_ARB_RR_EN defined → grants alternate m0, m1, m0, m1. Build again without the macro → all grants go to m0 until m0_req is dropped.
- Reset pulse with rst_n low during WAIT of a read → all outputs are 0 immediately and no ack pulses. A fresh read after reset completes normally.
- m0_req dropped 1 cycle after grant → the transaction finishes and m0_ack pulses once. There is no second grant.
- RD_LAT=1 sweep with fx_q=0xFF → capture occurs in the cycle after fx_rd. The read completes in 4 cycles and m0_rdata=0xFF.
